// File: rtl/tconv_pkg.sv
// Shared definitions for the transposed-convolution output path:
// frame geometry derivation and the output-buffer controller state encoding.
package tconv_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_FILL  = 2'd1,
      ST_DRAIN = 2'd2,
      ST_DONE  = 2'd3
   } obuf_state_t;

   // Output side of a transposed convolution: (ifm-1)*stride - 2*pad + kernel
   function automatic int unsigned calc_depth(input int unsigned ifm,
                                              input int unsigned kernel,
                                              input int unsigned stride,
                                              input int unsigned pad);
      return (ifm - 1) * stride - 2 * pad + kernel;
   endfunction

   function automatic int unsigned calc_total(input int unsigned depth);
      return depth * depth;
   endfunction

endpackage

// File: rtl/tconv_skid2.sv
// Two-entry skid FIFO between the 1-cycle buffer read and the downstream
// valid/ready port; the head entry is the registered output.
module tconv_skid2 #(
   parameter int unsigned DATA_WIDTH = 16
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  clr,
   input  logic                  push,
   input  logic [DATA_WIDTH-1:0] push_data,
   input  logic                  pop,
   output logic [DATA_WIDTH-1:0] head_data,
   output logic                  head_valid,
   output logic [1:0]            occ
);

   logic [DATA_WIDTH-1:0] r_d0;
   logic [DATA_WIDTH-1:0] r_d1;
   logic [1:0]            r_occ;

   // r_d0 is always the oldest entry; a pop shifts r_d1 forward
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_d0  <= '0;
         r_d1  <= '0;
         r_occ <= 2'd0;
      end else if (clr) begin
         r_d0  <= '0;
         r_d1  <= '0;
         r_occ <= 2'd0;
      end else begin
         unique case ({push, pop})
            2'b10: begin
               if (r_occ == 2'd0) r_d0 <= push_data;
               else               r_d1 <= push_data;
               r_occ <= r_occ + 2'd1;
            end
            2'b01: begin
               r_d0  <= r_d1;
               r_occ <= r_occ - 2'd1;
            end
            2'b11: begin
               if (r_occ == 2'd1) begin
                  r_d0 <= push_data;
               end else begin
                  r_d0 <= r_d1;
                  r_d1 <= push_data;
               end
            end
            default: ;
         endcase
      end
   end

   assign head_data  = r_d0;
   assign head_valid = (r_occ != 2'd0);
   assign occ        = r_occ;

endmodule

// File: rtl/tconv_obuf_ctrl.sv
// Output frame buffer sequencer: admits one DEPTH*DEPTH frame into the buffer,
// then drains it downstream with row/column tags and backpressure absorption.
module tconv_obuf_ctrl
   import tconv_pkg::*;
#(
   parameter int unsigned DATA_WIDTH  = 16,
   parameter int unsigned IFM_SIZE    = 9,
   parameter int unsigned KERNEL_SIZE = 4,
   parameter int unsigned STRIDE      = 2,
   parameter int unsigned PAD         = 2,
   localparam int unsigned DEPTH      = calc_depth(IFM_SIZE, KERNEL_SIZE, STRIDE, PAD),
   localparam int unsigned TOTAL      = calc_total(DEPTH),
   localparam int unsigned CW         = $clog2(TOTAL + 1),
   localparam int unsigned RW         = $clog2(DEPTH)
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   input  logic                  clear,
   input  logic [DATA_WIDTH-1:0] in_data,
   input  logic                  in_valid,
   output logic                  in_ready,
   output logic                  buf_we,
   output logic [DATA_WIDTH-1:0] buf_din,
   output logic                  buf_re,
   input  logic [DATA_WIDTH-1:0] buf_dout,
   output logic [DATA_WIDTH-1:0] out_data,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [RW-1:0]         out_row,
   output logic [RW-1:0]         out_col,
   output logic                  busy,
   output logic                  frame_done
);

   obuf_state_t           r_state;
   obuf_state_t           w_next;
   logic [CW-1:0]         r_wr_cnt;
   logic [CW-1:0]         r_rd_cnt;
   logic [RW-1:0]         r_row;
   logic [RW-1:0]         r_col;
   logic                  r_inflight;
   logic                  w_we;
   logic                  w_re;
   logic                  w_pop;
   logic                  w_last_pop;
   logic                  w_skid_valid;
   logic [1:0]            w_occ;
   logic [2:0]            w_level;
   logic [DATA_WIDTH-1:0] w_skid_data;

   assign w_pop      = w_skid_valid & out_ready;
   assign w_level    = 3'(w_occ) + 3'(r_inflight);
   assign w_last_pop = w_pop & (r_row == RW'(DEPTH - 1)) & (r_col == RW'(DEPTH - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= ST_IDLE;
      else        r_state <= w_next;
   end

   // Reads are only issued while the skid plus the in-flight read has room
   always_comb begin
      w_next = r_state;
      w_we   = 1'b0;
      w_re   = 1'b0;
      unique case (r_state)
         ST_IDLE:  if (start) w_next = ST_FILL;
         ST_FILL: begin
            w_we = in_valid;
            if (in_valid && (r_wr_cnt == CW'(TOTAL - 1))) w_next = ST_DRAIN;
         end
         ST_DRAIN: begin
            w_re = (r_rd_cnt < CW'(TOTAL)) && (w_level < (3'd2 + 3'(w_pop)));
            if (w_last_pop) w_next = ST_DONE;
         end
         ST_DONE:  w_next = ST_IDLE;
         default:  w_next = ST_IDLE;
      endcase
      if (clear) w_next = ST_IDLE;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr_cnt   <= '0;
         r_rd_cnt   <= '0;
         r_row      <= '0;
         r_col      <= '0;
         r_inflight <= 1'b0;
      end else begin
         r_inflight <= w_re & ~clear;
         if ((r_state == ST_IDLE) && start) r_wr_cnt <= '0;
         else if (w_we)                     r_wr_cnt <= r_wr_cnt + CW'(1);
         if (clear || ((r_state == ST_FILL) && (w_next == ST_DRAIN))) begin
            r_rd_cnt <= '0;
            r_row    <= '0;
            r_col    <= '0;
         end else begin
            if (w_re) r_rd_cnt <= r_rd_cnt + CW'(1);
            if (w_pop) begin
               if (r_col == RW'(DEPTH - 1)) begin
                  r_col <= '0;
                  r_row <= r_row + RW'(1);
               end else begin
                  r_col <= r_col + RW'(1);
               end
            end
         end
      end
   end

   tconv_skid2 #(
      .DATA_WIDTH (DATA_WIDTH)
   ) u_skid (
      .clk        (clk),
      .rst_n      (rst_n),
      .clr        (clear),
      .push       (r_inflight),
      .push_data  (buf_dout),
      .pop        (w_pop),
      .head_data  (w_skid_data),
      .head_valid (w_skid_valid),
      .occ        (w_occ)
   );

   assign in_ready   = (r_state == ST_FILL);
   assign buf_we     = w_we;
   assign buf_din    = in_data;
   assign buf_re     = w_re;
   assign out_data   = w_skid_data;
   assign out_valid  = w_skid_valid;
   assign out_row    = r_row;
   assign out_col    = r_col;
   assign busy       = (r_state != ST_IDLE);
   assign frame_done = (r_state == ST_DONE);

endmodule

// File: tb/tb_tconv_obuf_ctrl.sv
// Bench for tconv_obuf_ctrl: a behavioural frame buffer, a negedge monitor that
// logs every handshake, and one task per scenario comparing against frame order.
module tb_tconv_obuf_ctrl;

   localparam int DW    = 16;
   localparam int DEPTH = 16;
   localparam int TOTAL = DEPTH * DEPTH;
   localparam int RW    = 4;
   localparam int MAXP  = 8192;

   logic          clk;
   logic          rst_n;
   logic          start;
   logic          clear;
   logic [DW-1:0] in_data;
   logic          in_valid;
   logic          in_ready;
   logic          buf_we;
   logic [DW-1:0] buf_din;
   logic          buf_re;
   logic [DW-1:0] buf_dout;
   logic [DW-1:0] out_data;
   logic          out_valid;
   logic          out_ready;
   logic [RW-1:0] out_row;
   logic [RW-1:0] out_col;
   logic          busy;
   logic          frame_done;

   int errors = 0;
   int checks = 0;

   tconv_obuf_ctrl #(
      .DATA_WIDTH(DW), .IFM_SIZE(9), .KERNEL_SIZE(4), .STRIDE(2), .PAD(2)
   ) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .clear(clear),
      .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
      .buf_we(buf_we), .buf_din(buf_din), .buf_re(buf_re), .buf_dout(buf_dout),
      .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
      .out_row(out_row), .out_col(out_col), .busy(busy), .frame_done(frame_done)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Frame buffer: single write/read pointer FIFO, registered read, 0 when idle
   logic [DW-1:0] mem [TOTAL];
   int unsigned   wp, rp;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wp       <= 0;
         rp       <= 0;
         buf_dout <= '0;
      end else begin
         if (buf_we) begin
            mem[wp] <= buf_din;
            wp      <= (wp + 1) % TOTAL;
         end
         if (buf_re) begin
            buf_dout <= mem[rp];
            rp       <= (rp + 1) % TOTAL;
         end else begin
            buf_dout <= '0;
         end
      end
   end

   // Monitor: everything observed mid-cycle, cumulative counters
   int cyc = 0, we_total = 0, re_total = 0, done_total = 0, pop_total = 0;
   int re_viol = 0, unstable = 0, re_early = 0, we_extra = 0, re_extra = 0;
   int frame_we = 0, frame_re = 0, outstanding = 0, last_we_cyc = 0;
   logic [DW-1:0] pop_data [MAXP];
   int            pop_row  [MAXP];
   int            pop_col  [MAXP];
   int            pop_cyc  [MAXP];
   bit            prev_stall = 0;
   logic [DW-1:0] prev_data = '0;

   initial begin
      forever begin
         @(negedge clk);
         cyc++;
         if (!rst_n) begin
            frame_we = 0; frame_re = 0; outstanding = 0; prev_stall = 0;
         end else begin
            if (start && !busy) begin frame_we = 0; frame_re = 0; end
            if (buf_we) begin
               we_total++; frame_we++; last_we_cyc = cyc;
               if (frame_we > TOTAL) we_extra++;
            end
            if (buf_re) begin
               re_total++; frame_re++;
               if (frame_we < TOTAL) re_early++;
               if (frame_re > TOTAL) re_extra++;
               if (outstanding - int'(out_valid && out_ready) >= 2) re_viol++;
            end
            if (prev_stall && (!out_valid || out_data !== prev_data)) unstable++;
            if (out_valid && out_ready) begin
               if (pop_total < MAXP) begin
                  pop_data[pop_total] = out_data;
                  pop_row[pop_total]  = int'(out_row);
                  pop_col[pop_total]  = int'(out_col);
                  pop_cyc[pop_total]  = cyc;
               end
               pop_total++;
            end
            if (frame_done) done_total++;
            outstanding = outstanding + int'(buf_re) - int'(out_valid && out_ready);
            prev_stall  = out_valid && !out_ready;
            prev_data   = out_data;
            if (clear) begin outstanding = 0; prev_stall = 0; end
         end
      end
   end

   // Drives one frame of base+k data; returns once frame_done has been seen
   task automatic run_frame(input int base, input int duty, input int rmode, input bit poke,
                            output bit got_done, output int pb);
      int wi = 0;
      int d0 = done_total;
      got_done = 0;
      pb = pop_total;
      for (int c = 0; c < 6000; c++) begin
         start    = (c == 0) || (poke && (c == 50 || c == 400));
         in_valid = ($urandom_range(99) < duty);
         in_data  = DW'(base + wi);
         if (in_valid && in_ready) wi++;
         case (rmode)
            0:       out_ready = 1'b1;
            1:       out_ready = (c % 4 == 0) || (c % 4 == 3);
            default: out_ready = 1'($urandom_range(1));
         endcase
         @(posedge clk); #1;
         if (done_total > d0) begin got_done = 1; break; end
      end
      start = 0; in_valid = 0; out_ready = 0;
   endtask

   task automatic test_reset();
      rst_n = 0; start = 0; clear = 0; in_valid = 0; in_data = '0; out_ready = 0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      checks++;
      if ({in_ready, buf_we, buf_re, out_valid, busy, frame_done} !== 6'b0) begin
         errors++;
         $display("FAIL reset_ctrl got %b want 000000",
                  {in_ready, buf_we, buf_re, out_valid, busy, frame_done});
      end
      checks++;
      if (out_data !== '0 || out_row !== '0 || out_col !== '0) begin
         errors++;
         $display("FAIL reset_out got data=%0h row=%0d col=%0d want 0/0/0", out_data, out_row, out_col);
      end
      @(posedge clk); #1 rst_n = 1;
      @(negedge clk);
      checks++;
      if (busy !== 1'b0 || in_ready !== 1'b0) begin
         errors++;
         $display("FAIL reset_idle got busy=%b in_ready=%b want 0/0", busy, in_ready);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_basic();
      bit ok; int pb; int wb = we_total; int d0 = done_total;
      run_frame(0, 100, 0, 0, ok, pb);
      checks++;
      if (!ok) begin errors++; $display("FAIL basic_timeout got no frame_done want one"); end
      repeat (5) @(posedge clk); #1;
      checks++;
      if (we_total - wb !== TOTAL) begin
         errors++; $display("FAIL basic_writes got %0d want %0d", we_total - wb, TOTAL);
      end
      checks++;
      if (pop_total - pb !== TOTAL) begin
         errors++; $display("FAIL basic_pops got %0d want %0d", pop_total - pb, TOTAL);
      end
      checks++;
      if (done_total - d0 !== 1) begin
         errors++; $display("FAIL basic_done got %0d want 1", done_total - d0);
      end
      for (int k = 0; k < TOTAL; k++) begin
         checks++;
         if (pop_data[pb+k] !== DW'(k) || pop_row[pb+k] !== k / DEPTH || pop_col[pb+k] !== k % DEPTH) begin
            errors++;
            $display("FAIL basic_sample[%0d] got %0d@(%0d,%0d) want %0d@(%0d,%0d)", k,
                     pop_data[pb+k], pop_row[pb+k], pop_col[pb+k], k, k / DEPTH, k % DEPTH);
         end
      end
      checks++;
      if (pop_cyc[pb+TOTAL-1] - pop_cyc[pb] !== TOTAL - 1) begin
         errors++;
         $display("FAIL basic_rate got span %0d want %0d", pop_cyc[pb+TOTAL-1] - pop_cyc[pb], TOTAL - 1);
      end
      checks++;
      if (pop_cyc[pb] !== last_we_cyc + 3) begin
         errors++;
         $display("FAIL basic_latency got first pop %0d want %0d", pop_cyc[pb], last_we_cyc + 3);
      end
      checks++;
      if (busy !== 1'b0) begin errors++; $display("FAIL basic_idle got busy=%b want 0", busy); end
   endtask

   task automatic test_backpressure(input int rmode, input string nm);
      bit ok; int pb; int base = int'($urandom_range(30000));
      int v0 = re_viol, u0 = unstable, x0 = re_extra;
      run_frame(base, 100, rmode, 0, ok, pb);
      checks++;
      if (!ok) begin errors++; $display("FAIL %s_timeout got no frame_done want one", nm); end
      checks++;
      if (pop_total - pb !== TOTAL) begin
         errors++; $display("FAIL %s_pops got %0d want %0d", nm, pop_total - pb, TOTAL);
      end
      for (int k = 0; k < TOTAL; k++) begin
         checks++;
         if (pop_data[pb+k] !== DW'(base + k)) begin
            errors++;
            $display("FAIL %s_data[%0d] got %0h want %0h", nm, k, pop_data[pb+k], DW'(base + k));
         end
      end
      checks++;
      if (re_viol - v0 !== 0) begin
         errors++; $display("FAIL %s_re_full got %0d reads with 2 held want 0", nm, re_viol - v0);
      end
      checks++;
      if (unstable - u0 !== 0) begin
         errors++; $display("FAIL %s_stall got %0d unstable cycles want 0", nm, unstable - u0);
      end
      checks++;
      if (re_extra - x0 !== 0) begin
         errors++; $display("FAIL %s_overread got %0d extra reads want 0", nm, re_extra - x0);
      end
      repeat (3) @(posedge clk); #1;
   endtask

   task automatic test_sparse_input();
      bit ok; int pb; int base = int'($urandom_range(40000));
      int wb = we_total, e0 = re_early;
      run_frame(base, 25, 0, 0, ok, pb);
      checks++;
      if (!ok) begin errors++; $display("FAIL sparse_timeout got no frame_done want one"); end
      checks++;
      if (we_total - wb !== TOTAL) begin
         errors++; $display("FAIL sparse_writes got %0d want %0d", we_total - wb, TOTAL);
      end
      checks++;
      if (re_early - e0 !== 0) begin
         errors++; $display("FAIL sparse_early_drain got %0d reads before frame full want 0", re_early - e0);
      end
      for (int k = 0; k < TOTAL; k++) begin
         checks++;
         if (pop_data[pb+k] !== DW'(base + k)) begin
            errors++;
            $display("FAIL sparse_data[%0d] got %0h want %0h", k, pop_data[pb+k], DW'(base + k));
         end
      end
      repeat (3) @(posedge clk); #1;
   endtask

   task automatic test_back_to_back();
      bit ok1, ok2; int pb1, pb2; int base1 = int'($urandom_range(5000)) + 2000;
      run_frame(base1, 100, 2, 0, ok1, pb1);
      run_frame(1000, 100, 0, 0, ok2, pb2);
      checks++;
      if (!ok1 || !ok2) begin
         errors++; $display("FAIL b2b_timeout got done=%b%b want 11", ok1, ok2);
      end
      for (int k = 0; k < TOTAL; k++) begin
         checks++;
         if (pop_data[pb1+k] !== DW'(base1 + k) || pop_data[pb2+k] !== DW'(1000 + k)) begin
            errors++;
            $display("FAIL b2b_data[%0d] got %0d/%0d want %0d/%0d", k, pop_data[pb1+k],
                     pop_data[pb2+k], base1 + k, 1000 + k);
         end
      end
      repeat (3) @(posedge clk); #1;
   endtask

   task automatic test_start_ignored();
      bit ok; int pb; int wb = we_total, rb = re_total, d0 = done_total;
      run_frame(500, 100, 0, 1, ok, pb);
      repeat (5) @(posedge clk); #1;
      checks++;
      if (!ok) begin errors++; $display("FAIL start_ign_timeout got no frame_done want one"); end
      checks++;
      if (we_total - wb !== TOTAL || re_total - rb !== TOTAL) begin
         errors++;
         $display("FAIL start_ign_counts got we=%0d re=%0d want %0d/%0d", we_total - wb, re_total - rb, TOTAL, TOTAL);
      end
      checks++;
      if (done_total - d0 !== 1) begin
         errors++; $display("FAIL start_ign_done got %0d want 1", done_total - d0);
      end
      for (int k = 0; k < TOTAL; k++) begin
         checks++;
         if (pop_data[pb+k] !== DW'(500 + k)) begin
            errors++;
            $display("FAIL start_ign_data[%0d] got %0d want %0d", k, pop_data[pb+k], 500 + k);
         end
      end
   endtask

   task automatic test_clear();
      bit ok; int pb; int wi = 0; int d0 = done_total; int base = int'($urandom_range(20000));
      start = 1; @(posedge clk); #1 start = 0;
      in_valid = 1; out_ready = 1;
      for (int c = 0; c < 1000 && wi < 100; c++) begin
         in_data = DW'(c);
         if (in_ready) wi++;
         @(posedge clk); #1;
      end
      checks++;
      if (wi !== 100) begin errors++; $display("FAIL clear_fill got %0d writes want 100", wi); end
      in_valid = 0; clear = 1;
      @(posedge clk); #1 clear = 0;
      @(negedge clk);
      checks++;
      if (busy !== 1'b0 || in_ready !== 1'b0 || out_valid !== 1'b0) begin
         errors++;
         $display("FAIL clear_idle got busy=%b in_ready=%b out_valid=%b want 000", busy, in_ready, out_valid);
      end
      repeat (20) @(posedge clk);
      checks++;
      if (done_total !== d0) begin
         errors++; $display("FAIL clear_no_done got %0d pulses want 0", done_total - d0);
      end
      #1 rst_n = 0;
      @(posedge clk); #1 rst_n = 1;
      @(posedge clk); #1;
      run_frame(base, 100, 2, 0, ok, pb);
      checks++;
      if (!ok || pop_total - pb !== TOTAL) begin
         errors++; $display("FAIL clear_fresh got done=%b pops=%0d want 1/%0d", ok, pop_total - pb, TOTAL);
      end
      for (int k = 0; k < TOTAL; k++) begin
         checks++;
         if (pop_data[pb+k] !== DW'(base + k)) begin
            errors++;
            $display("FAIL clear_fresh_data[%0d] got %0h want %0h", k, pop_data[pb+k], DW'(base + k));
         end
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_backpressure(1, "bp_pattern");
      test_backpressure(2, "bp_random");
      test_sparse_input();
      test_back_to_back();
      test_start_ignored();
      test_clear();
      checks++;
      if (we_extra !== 0) begin errors++; $display("FAIL overwrite got %0d excess writes want 0", we_extra); end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
